// File: rtl/memory_cycle_pkg.sv
// Shared pipeline definitions for the memory stage: FSM state encoding,
// default datapath width and access decode helper.
package memory_cycle_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // A store wins when both request bits are set, so either bit starts an access.
  function automatic logic is_access(input logic mem_write, input logic result_src);
    return mem_write | result_src;
  endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave).
interface memory_cycle_if
  import memory_cycle_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/memory_cycle_wait_fsm.sv
// IDLE/WAIT sequencer for one outstanding data-memory access, with an
// optional WAIT-cycle timeout enabled by `define MEM_TIMEOUT_EN.
module mem_wait_fsm
  import memory_cycle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic access_i,
  input  logic ack_i,
  output logic req_o,
  output logic stall_o,
`ifdef MEM_TIMEOUT_EN
  output logic err_o,
`endif
  output logic timeout_o
);

  mem_state_e state_q, state_d;
  logic       req_s, stall_s, timeout_s, timeout_hit_s;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout_hit_s = (cnt_q == LIMIT);

  // Counter idles at zero in IDLE, so it is already cleared on entry to WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      err_q <= timeout_s;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_hit_s = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_s     = 1'b0;
    stall_s   = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_i) begin
          req_s = 1'b1;
          if (ack_i) begin
            state_d = IDLE;
          end else begin
            stall_s = 1'b1;
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        req_s = 1'b1;
        if (ack_i) begin
          state_d = IDLE;
        end else if (timeout_hit_s) begin
          timeout_s = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset forces the bus quiet and releases the pipeline immediately.
  assign req_o     = req_s & rst;
  assign stall_o   = stall_s & rst;
  assign timeout_o = timeout_s & rst;

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: issues data-memory accesses, stalls upstream while
// waiting, and holds the M-to-W register bank. Optional feature macro:
// MEM_TIMEOUT_EN (adds the WAIT timeout and the ErrM output).
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteM,
  input  logic             MemWriteM,
  input  logic             ResultSrcM,
  input  logic [4:0]       RD_M,
  input  logic [XLEN-1:0]  PCPlus4M,
  input  logic [XLEN-1:0]  WriteDataM,
  input  logic [XLEN-1:0]  ALU_ResultM,
  memory_cycle_if.master   dmem,
  output logic             StallM,
`ifdef MEM_TIMEOUT_EN
  output logic             ErrM,
`endif
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic [4:0]       RD_W,
  output logic [XLEN-1:0]  PCPlus4W,
  output logic [XLEN-1:0]  ALU_ResultW,
  output logic [XLEN-1:0]  ReadDataW
);

  logic access_s, is_load_s, req_s, stall_s, timeout_s;

  assign access_s  = is_access(MemWriteM, ResultSrcM);
  assign is_load_s = ResultSrcM & ~MemWriteM;

  mem_wait_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .access_i  (access_s),
    .ack_i     (dmem.dmem_ack),
    .req_o     (req_s),
    .stall_o   (stall_s),
`ifdef MEM_TIMEOUT_EN
    .err_o     (ErrM),
`endif
    .timeout_o (timeout_s)
  );

  // Upstream holds the M inputs during a stall, so the request stays stable.
  assign dmem.dmem_req   = req_s;
  assign dmem.dmem_we    = req_s & MemWriteM;
  assign dmem.dmem_addr  = req_s ? ALU_ResultM : {XLEN{1'b0}};
  assign dmem.dmem_wdata = req_s ? WriteDataM  : {XLEN{1'b0}};
  assign StallM          = stall_s;

  logic            regwrite_q, resultsrc_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pcplus4_q, alu_q, rdata_q;

  // A stalled edge inserts a bubble; a timed-out access completes without writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= 5'd0;
      pcplus4_q   <= {XLEN{1'b0}};
      alu_q       <= {XLEN{1'b0}};
      rdata_q     <= {XLEN{1'b0}};
    end else if (!stall_s) begin
      regwrite_q  <= RegWriteM & ~timeout_s;
      resultsrc_q <= ResultSrcM;
      rd_q        <= RD_M;
      pcplus4_q   <= PCPlus4M;
      alu_q       <= ALU_ResultM;
      rdata_q     <= (req_s & is_load_s & ~timeout_s) ? dmem.dmem_rdata : {XLEN{1'b0}};
    end else begin
      regwrite_q  <= 1'b0;
    end
  end

  assign RegWriteW   = regwrite_q;
  assign ResultSrcW  = resultsrc_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pcplus4_q;
  assign ALU_ResultW = alu_q;
  assign ReadDataW   = rdata_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle; covers the timeout path
// when MEM_TIMEOUT_EN is defined.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [63:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        StallM, RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [63:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MEM_TIMEOUT_EN
  logic        ErrM;
`endif
  int nvec = 0;
  int nerr = 0;

  memory_cycle_if #(.XLEN(64)) dmem ();

  memory_cycle #(
    .XLEN (64),
`ifdef MEM_TIMEOUT_EN
    .TIMEOUT_CYCLES (4)
`else
    .TIMEOUT_CYCLES (255)
`endif
  ) dut (
    .clk (clk), .rst (rst),
    .RegWriteM (RegWriteM), .MemWriteM (MemWriteM), .ResultSrcM (ResultSrcM),
    .RD_M (RD_M), .PCPlus4M (PCPlus4M), .WriteDataM (WriteDataM), .ALU_ResultM (ALU_ResultM),
    .dmem (dmem), .StallM (StallM),
`ifdef MEM_TIMEOUT_EN
    .ErrM (ErrM),
`endif
    .RegWriteW (RegWriteW), .ResultSrcW (ResultSrcW), .RD_W (RD_W),
    .PCPlus4W (PCPlus4W), .ALU_ResultW (ALU_ResultW), .ReadDataW (ReadDataW)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [63:0] pc, input logic [63:0] wd, input logic [63:0] alu);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_m(1'b1, 1'b0, 1'b1, 5'd1, 64'h4, 64'h0, 64'h8);
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 64'h0;
    #2;
    nvec++; if (dmem.dmem_req !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b exp 0", dmem.dmem_req); end
    nvec++; if (StallM !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b exp 0", StallM); end
    nvec++; if (RegWriteW !== 1'b0) begin nerr++; $display("FAIL reset_regwrite_w: got %b exp 0", RegWriteW); end
    nvec++; if (ALU_ResultW !== 64'h0) begin nerr++; $display("FAIL reset_alu_w: got %h exp 0", ALU_ResultW); end
    nvec++; if (ReadDataW !== 64'h0) begin nerr++; $display("FAIL reset_rdata_w: got %h exp 0", ReadDataW); end
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    #10 rst = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    set_m(1'b1, 1'b0, 1'b0, 5'd5, 64'h44, 64'h0, 64'h10);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'hFFFF;
    #1;
    nvec++; if (dmem.dmem_req !== 1'b0) begin nerr++; $display("FAIL alu_req: got %b exp 0", dmem.dmem_req); end
    nvec++; if (StallM !== 1'b0) begin nerr++; $display("FAIL alu_stall: got %b exp 0", StallM); end
    tick();
    nvec++; if (ALU_ResultW !== 64'h10) begin nerr++; $display("FAIL alu_result_w: got %h exp 10", ALU_ResultW); end
    nvec++; if (RD_W !== 5'd5) begin nerr++; $display("FAIL alu_rd_w: got %0d exp 5", RD_W); end
    nvec++; if (RegWriteW !== 1'b1) begin nerr++; $display("FAIL alu_regwrite_w: got %b exp 1", RegWriteW); end
    nvec++; if (PCPlus4W !== 64'h44) begin nerr++; $display("FAIL alu_pc_w: got %h exp 44", PCPlus4W); end
    nvec++; if (ReadDataW !== 64'h0) begin nerr++; $display("FAIL alu_rdata_w: got %h exp 0", ReadDataW); end
  endtask

  task automatic test_load_fast();
    set_m(1'b1, 1'b0, 1'b1, 5'd7, 64'h48, 64'h0, 64'h100);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'hDEAD;
    #1;
    nvec++; if (dmem.dmem_req !== 1'b1) begin nerr++; $display("FAIL ldf_req: got %b exp 1", dmem.dmem_req); end
    nvec++; if (dmem.dmem_we !== 1'b0) begin nerr++; $display("FAIL ldf_we: got %b exp 0", dmem.dmem_we); end
    nvec++; if (dmem.dmem_addr !== 64'h100) begin nerr++; $display("FAIL ldf_addr: got %h exp 100", dmem.dmem_addr); end
    nvec++; if (StallM !== 1'b0) begin nerr++; $display("FAIL ldf_stall: got %b exp 0", StallM); end
    tick();
    nvec++; if (ReadDataW !== 64'hDEAD) begin nerr++; $display("FAIL ldf_rdata_w: got %h exp dead", ReadDataW); end
    nvec++; if (ResultSrcW !== 1'b1) begin nerr++; $display("FAIL ldf_resultsrc_w: got %b exp 1", ResultSrcW); end
    nvec++; if (RD_W !== 5'd7) begin nerr++; $display("FAIL ldf_rd_w: got %0d exp 7", RD_W); end
  endtask

  task automatic test_store_wait();
    set_m(1'b0, 1'b1, 1'b0, 5'd0, 64'h4C, 64'h55, 64'h80);
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 64'hBAD0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem.dmem_ack = 1'b1;
      #1;
      nvec++; if (StallM !== (i < 3)) begin nerr++; $display("FAIL st_stall[%0d]: got %b exp %b", i, StallM, (i < 3)); end
      nvec++; if (dmem.dmem_we !== 1'b1) begin nerr++; $display("FAIL st_we[%0d]: got %b exp 1", i, dmem.dmem_we); end
      nvec++; if (dmem.dmem_addr !== 64'h80) begin nerr++; $display("FAIL st_addr[%0d]: got %h exp 80", i, dmem.dmem_addr); end
      nvec++; if (dmem.dmem_wdata !== 64'h55) begin nerr++; $display("FAIL st_wdata[%0d]: got %h exp 55", i, dmem.dmem_wdata); end
      tick();
      if (i < 3) begin
        nvec++; if (RegWriteW !== 1'b0) begin nerr++; $display("FAIL st_bubble[%0d]: got %b exp 0", i, RegWriteW); end
        nvec++; if (ALU_ResultW !== 64'h100) begin nerr++; $display("FAIL st_hold[%0d]: got %h exp 100", i, ALU_ResultW); end
      end
    end
    nvec++; if (ALU_ResultW !== 64'h80) begin nerr++; $display("FAIL st_done_alu_w: got %h exp 80", ALU_ResultW); end
    nvec++; if (ReadDataW !== 64'h0) begin nerr++; $display("FAIL st_done_rdata_w: got %h exp 0", ReadDataW); end
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    dmem.dmem_ack = 1'b0;
    #1;
    nvec++; if (dmem.dmem_req !== 1'b0) begin nerr++; $display("FAIL st_idle_req: got %b exp 0", dmem.dmem_req); end
  endtask

  task automatic test_load_wait();
    set_m(1'b1, 1'b0, 1'b1, 5'd9, 64'h50, 64'h0, 64'h200);
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 64'hBAD;
    #1;
    nvec++; if (StallM !== 1'b1) begin nerr++; $display("FAIL ldw_stall: got %b exp 1", StallM); end
    tick();
    nvec++; if (RegWriteW !== 1'b0) begin nerr++; $display("FAIL ldw_bubble: got %b exp 0", RegWriteW); end
    nvec++; if (ReadDataW !== 64'h0) begin nerr++; $display("FAIL ldw_no_early_sample: got %h exp 0", ReadDataW); end
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'h1234;
    #1;
    nvec++; if (StallM !== 1'b0) begin nerr++; $display("FAIL ldw_stall_drop: got %b exp 0", StallM); end
    tick();
    nvec++; if (ReadDataW !== 64'h1234) begin nerr++; $display("FAIL ldw_rdata_w: got %h exp 1234", ReadDataW); end
    nvec++; if (ALU_ResultW !== 64'h200) begin nerr++; $display("FAIL ldw_alu_w: got %h exp 200", ALU_ResultW); end
    nvec++; if (RegWriteW !== 1'b1) begin nerr++; $display("FAIL ldw_regwrite_w: got %b exp 1", RegWriteW); end
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    dmem.dmem_ack = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    set_m(1'b1, 1'b0, 1'b1, 5'd3, 64'h60, 64'h0, 64'h300);
    dmem.dmem_ack = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    nvec++; if (RegWriteW !== 1'b0 || ResultSrcW !== 1'b0 || RD_W !== 5'd0)
      begin nerr++; $display("FAIL rstw_ctrl: got rw=%b rs=%b rd=%0d exp 0 0 0", RegWriteW, ResultSrcW, RD_W); end
    nvec++; if (ALU_ResultW !== 64'h0 || PCPlus4W !== 64'h0 || ReadDataW !== 64'h0)
      begin nerr++; $display("FAIL rstw_data: got alu=%h pc=%h rd=%h exp 0", ALU_ResultW, PCPlus4W, ReadDataW); end
    nvec++; if (dmem.dmem_req !== 1'b0 || StallM !== 1'b0)
      begin nerr++; $display("FAIL rstw_bus: got req=%b stall=%b exp 0 0", dmem.dmem_req, StallM); end
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'hDEAD;
    rst = 1'b1;
    #1;
    nvec++; if (dmem.dmem_req !== 1'b0) begin nerr++; $display("FAIL rstw_idle_req: got %b exp 0", dmem.dmem_req); end
    tick();
    nvec++; if (RegWriteW !== 1'b0 || ReadDataW !== 64'h0)
      begin nerr++; $display("FAIL rstw_no_wb: got rw=%b rd=%h exp 0 0", RegWriteW, ReadDataW); end
    dmem.dmem_ack = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    set_m(1'b1, 1'b0, 1'b1, 5'd4, 64'h70, 64'h0, 64'h400);
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 64'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (StallM !== (i < 4)) begin nerr++; $display("FAIL tmo_stall[%0d]: got %b exp %b", i, StallM, (i < 4)); end
      nvec++; if (ErrM !== 1'b0) begin nerr++; $display("FAIL tmo_err_early[%0d]: got %b exp 0", i, ErrM); end
      tick();
    end
    set_m(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    nvec++; if (ErrM !== 1'b1) begin nerr++; $display("FAIL tmo_err: got %b exp 1", ErrM); end
    nvec++; if (RegWriteW !== 1'b0) begin nerr++; $display("FAIL tmo_regwrite_w: got %b exp 0", RegWriteW); end
    nvec++; if (ReadDataW !== 64'h0) begin nerr++; $display("FAIL tmo_rdata_w: got %h exp 0", ReadDataW); end
    tick();
    nvec++; if (ErrM !== 1'b0) begin nerr++; $display("FAIL tmo_err_pulse: got %b exp 0", ErrM); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_fast();
    test_store_wait();
    test_load_wait();
    test_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
